// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle instruction sequencer for a 16-bit datapath.
//
// Ports:
//   clk            - single clock; all state changes on the rising edge
//   reset          - asynchronous active-low reset (0 = reset)
//   op_code        - instruction bits 15-12
//   ext_op_code    - instruction bits 7-4
//   cond           - branch condition field, instruction bits 11-8
//   psr_flags      - ALU flags; Z is bit 6
//   mem_ready      - memory read/write completes this cycle
//   reg_write      - register file write strobe
//   alu_A_src      - ALU A select (1 = register A, 0 = PC)
//   alu_B_src      - ALU B select (0 = register B, 1 = immediate/displacement)
//   pc_en          - PC load strobe
//   pc_src         - PC source (0 ALU, 1 reg B, 2 PC+1)
//   reg_write_src  - register write data source (0 ALU, 1 memory, 2 PC+1)
//   alu_cont       - ALU operation select
//   loading        - memory read in progress
//   storing        - memory write in progress
//   instruction_en - instruction register load strobe
//   state_dbg      - current state encoding
//
// The state register is the only storage; every output is decoded
// combinationally from the state and the live instruction/flag inputs.

module cpu_controller #(
  parameter int unsigned ALU_CONT_BITS    = 6,
  parameter int unsigned OP_CODE_BITS     = 4,
  parameter int unsigned EXT_OP_CODE_BITS = 4,
  parameter int unsigned WIDTH            = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [OP_CODE_BITS-1:0]     op_code,
  input  logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
  input  logic [3:0]                  cond,
  input  logic [WIDTH-1:0]            psr_flags,
  input  logic                        mem_ready,
  output logic                        reg_write,
  output logic                        alu_A_src,
  output logic                        alu_B_src,
  output logic                        pc_en,
  output logic [1:0]                  pc_src,
  output logic [1:0]                  reg_write_src,
  output logic [ALU_CONT_BITS-1:0]    alu_cont,
  output logic                        loading,
  output logic                        storing,
  output logic                        instruction_en,
  output logic [2:0]                  state_dbg
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExecR  = 3'd2,
    StExecI  = 3'd3,
    StLoad   = 3'd4,
    StStore  = 3'd5,
    StJal    = 3'd6,
    StBranch = 3'd7
  } state_e;

  localparam logic [3:0] OpRType  = 4'b0000;
  localparam logic [3:0] OpMem    = 4'b0100;
  localparam logic [3:0] OpBranch = 4'b1100;
  localparam logic [3:0] ExtLoad  = 4'b0000;
  localparam logic [3:0] ExtStore = 4'b0100;
  localparam logic [3:0] ExtJal   = 4'b1000;
  localparam logic [3:0] CodeCmp  = 4'b1011;
  localparam logic [3:0] CodeAdd  = 4'b0101;

  state_e state_q, state_d;

  logic [3:0] op4;
  logic [3:0] ext4;
  logic       z_flag;
  logic       br_taken;

  assign op4    = 4'(op_code);
  assign ext4   = 4'(ext_op_code);
  assign z_flag = psr_flags[6];

  // ALU operations shared by the register and immediate encodings.
  function automatic logic is_alu_code(input logic [3:0] code);
    unique case (code)
      4'b0001, 4'b0010, 4'b0011, 4'b0101,
      4'b1001, 4'b1011, 4'b1101: is_alu_code = 1'b1;
      default:                   is_alu_code = 1'b0;
    endcase
  endfunction

  always_comb begin
    br_taken = ((cond == 4'b0000) && z_flag)  ||
               ((cond == 4'b0001) && !z_flag) ||
               (cond == 4'b1110);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    reg_write      = 1'b0;
    alu_A_src      = 1'b0;
    alu_B_src      = 1'b0;
    pc_en          = 1'b0;
    pc_src         = 2'd2;
    reg_write_src  = 2'd0;
    alu_cont       = '0;
    loading        = 1'b0;
    storing        = 1'b0;
    instruction_en = 1'b0;

    // While reset is low the state is already forced to FETCH, but FETCH
    // would still react to mem_ready; gate everything to defaults here.
    if (reset) begin
      unique case (state_q)
        StFetch: begin
          if (mem_ready) begin
            instruction_en = 1'b1;
            pc_en          = 1'b1;
            pc_src         = 2'd2;
            state_d        = StDecode;
          end
        end
        StDecode: begin
          if (op4 == OpRType) begin
            state_d = is_alu_code(ext4) ? StExecR : StFetch;
          end else if (is_alu_code(op4)) begin
            state_d = StExecI;
          end else if (op4 == OpMem) begin
            unique case (ext4)
              ExtLoad:  state_d = StLoad;
              ExtStore: state_d = StStore;
              ExtJal:   state_d = StJal;
              default:  state_d = StFetch;
            endcase
          end else if (op4 == OpBranch) begin
            state_d = StBranch;
          end else begin
            state_d = StFetch;
          end
        end
        StExecR: begin
          alu_A_src = 1'b1;
          alu_B_src = 1'b0;
          alu_cont  = ALU_CONT_BITS'(ext4);
          reg_write = (ext4 != CodeCmp);
          state_d   = StFetch;
        end
        StExecI: begin
          alu_A_src = 1'b1;
          alu_B_src = 1'b1;
          alu_cont  = ALU_CONT_BITS'(op4);
          reg_write = (op4 != CodeCmp);
          state_d   = StFetch;
        end
        StLoad: begin
          loading = 1'b1;
          if (mem_ready) begin
            reg_write     = 1'b1;
            reg_write_src = 2'd1;
            state_d       = StFetch;
          end
        end
        StStore: begin
          storing = 1'b1;
          if (mem_ready) begin
            state_d = StFetch;
          end
        end
        StJal: begin
          reg_write     = 1'b1;
          reg_write_src = 2'd2;
          pc_en         = 1'b1;
          pc_src        = 2'd1;
          state_d       = StFetch;
        end
        StBranch: begin
          // PC was already incremented in FETCH, so PC + displacement is the target.
          if (br_taken) begin
            alu_A_src = 1'b0;
            alu_B_src = 1'b1;
            alu_cont  = ALU_CONT_BITS'(CodeAdd);
            pc_en     = 1'b1;
            pc_src    = 2'd0;
          end
          state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: each driven cycle pushes the expected
// output record; the observed record is captured mid-cycle and each test
// task drains and compares the two queues.

module tb_cpu_controller;

  logic        clk;
  logic        reset;
  logic [3:0]  op_code;
  logic [3:0]  ext_op_code;
  logic [3:0]  cond;
  logic [15:0] psr_flags;
  logic        mem_ready;
  logic        reg_write;
  logic        alu_A_src;
  logic        alu_B_src;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic [1:0]  reg_write_src;
  logic [5:0]  alu_cont;
  logic        loading;
  logic        storing;
  logic        instruction_en;
  logic [2:0]  state_dbg;

  typedef struct packed {
    logic [2:0] st;
    logic       rw;
    logic       as;
    logic       bs;
    logic       pe;
    logic       ld;
    logic       sto;
    logic       ie;
    logic [1:0] ps;
    logic [1:0] rws;
    logic [5:0] ac;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   total;
  int   bad;

  cpu_controller dut (
    .clk            (clk),
    .reset          (reset),
    .op_code        (op_code),
    .ext_op_code    (ext_op_code),
    .cond           (cond),
    .psr_flags      (psr_flags),
    .mem_ready      (mem_ready),
    .reg_write      (reg_write),
    .alu_A_src      (alu_A_src),
    .alu_B_src      (alu_B_src),
    .pc_en          (pc_en),
    .pc_src         (pc_src),
    .reg_write_src  (reg_write_src),
    .alu_cont       (alu_cont),
    .loading        (loading),
    .storing        (storing),
    .instruction_en (instruction_en),
    .state_dbg      (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  // Default output record for a given state.
  function automatic rec_t mk(input logic [2:0] st);
    rec_t r;
    r    = '0;
    r.st = st;
    r.ps = 2'd2;
    return r;
  endfunction

  function automatic rec_t sample();
    rec_t r;
    r.st  = state_dbg;
    r.rw  = reg_write;
    r.as  = alu_A_src;
    r.bs  = alu_B_src;
    r.pe  = pc_en;
    r.ld  = loading;
    r.sto = storing;
    r.ie  = instruction_en;
    r.ps  = pc_src;
    r.rws = reg_write_src;
    r.ac  = alu_cont;
    return r;
  endfunction

  // One clock cycle: drive inputs, record expectation, capture outputs mid-cycle.
  task automatic cyc(input logic [3:0] op, input logic [3:0] ext, input logic [3:0] cn,
                     input logic z, input logic mr, input rec_t e);
    op_code     = op;
    ext_op_code = ext;
    cond        = cn;
    psr_flags   = z ? 16'h0040 : 16'hffbf;
    mem_ready   = mr;
    exp_q.push_back(e);
    @(negedge clk);
    obs_q.push_back(sample());
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [3:0] op, input logic [3:0] ext,
                              input logic [3:0] cn, input logic z);
    rec_t e;
    e    = mk(3'd0);
    e.ie = 1'b1;
    e.pe = 1'b1;
    e.ps = 2'd2;
    cyc(op, ext, cn, z, 1'b1, e);
    cyc(op, ext, cn, z, 1'b0, mk(3'd1));
  endtask

  task automatic test_reset();
    rec_t e, o;
    reset = 1'b0;
    cyc(4'h0, 4'h5, 4'h0, 1'b0, 1'b1, mk(3'd0));
    cyc(4'h4, 4'h0, 4'h0, 1'b1, 1'b1, mk(3'd0));
    reset = 1'b1;
    cyc(4'h0, 4'h5, 4'h0, 1'b0, 1'b0, mk(3'd0));
    cyc(4'h0, 4'h5, 4'h0, 1'b0, 1'b0, mk(3'd0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_alu();
    logic [3:0] t_op[10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hb, 4'h3, 4'h1, 4'h2, 4'hd};
    logic [3:0] t_ext[10] = '{4'h5, 4'hb, 4'hd, 4'h9, 4'h1, 4'h4, 4'h0, 4'h8, 4'h5, 4'hb};
    logic       t_rw[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [5:0] t_ac[10] = '{6'h05, 6'h0b, 6'h0d, 6'h09, 6'h01, 6'h0b, 6'h03, 6'h01,
                             6'h02, 6'h0d};
    rec_t e, o;
    for (int i = 0; i < 10; i++) begin
      fetch_decode(t_op[i], t_ext[i], 4'he, 1'b1);
      e    = mk((t_op[i] == 4'h0) ? 3'd2 : 3'd3);
      e.as = 1'b1;
      e.bs = (t_op[i] != 4'h0);
      e.rw = t_rw[i];
      e.ac = t_ac[i];
      cyc(t_op[i], t_ext[i], 4'he, 1'b1, 1'b1, e);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL alu: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_load();
    rec_t e, o;
    fetch_decode(4'h4, 4'h0, 4'h0, 1'b0);
    e    = mk(3'd4);
    e.ld = 1'b1;
    for (int i = 0; i < 3; i++) cyc(4'h4, 4'h0, 4'h0, 1'b0, 1'b0, e);
    e.rw  = 1'b1;
    e.rws = 2'd1;
    cyc(4'h4, 4'h0, 4'h0, 1'b0, 1'b1, e);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL load: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_store();
    rec_t e, o;
    fetch_decode(4'h4, 4'h4, 4'h0, 1'b0);
    e     = mk(3'd5);
    e.sto = 1'b1;
    for (int i = 0; i < 2; i++) cyc(4'h4, 4'h4, 4'h0, 1'b0, 1'b0, e);
    cyc(4'h4, 4'h4, 4'h0, 1'b0, 1'b1, e);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL store: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_jal();
    rec_t e, o;
    fetch_decode(4'h4, 4'h8, 4'h0, 1'b0);
    e     = mk(3'd6);
    e.rw  = 1'b1;
    e.rws = 2'd2;
    e.pe  = 1'b1;
    e.ps  = 2'd1;
    cyc(4'h4, 4'h8, 4'h0, 1'b0, 1'b0, e);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL jal: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_branch();
    logic [3:0] t_cn[8] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'he, 4'he, 4'h2, 4'hf};
    logic       t_z[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       t_tk[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rec_t e, o;
    for (int i = 0; i < 8; i++) begin
      fetch_decode(4'hc, 4'h0, t_cn[i], t_z[i]);
      e = mk(3'd7);
      if (t_tk[i]) begin
        e.bs = 1'b1;
        e.ac = 6'b000101;
        e.pe = 1'b1;
        e.ps = 2'd0;
      end
      cyc(4'hc, 4'h0, t_cn[i], t_z[i], 1'b1, e);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL branch: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] t_op[4]  = '{4'hf, 4'h0, 4'h4, 4'h8};
    logic [3:0] t_ext[4] = '{4'h5, 4'h0, 4'h1, 4'h5};
    rec_t e, o;
    for (int i = 0; i < 4; i++) begin
      fetch_decode(t_op[i], t_ext[i], 4'he, 1'b1);
      // Decoded as NOP: back in FETCH, idle while memory is not ready.
      cyc(t_op[i], t_ext[i], 4'he, 1'b1, 1'b0, mk(3'd0));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL illegal: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    rec_t e, o;
    fetch_decode(4'h4, 4'h4, 4'h0, 1'b0);
    e     = mk(3'd5);
    e.sto = 1'b1;
    cyc(4'h4, 4'h4, 4'h0, 1'b0, 1'b0, e);
    reset = 1'b0;
    cyc(4'h4, 4'h4, 4'h0, 1'b0, 1'b0, mk(3'd0));
    cyc(4'h4, 4'h4, 4'h0, 1'b0, 1'b1, mk(3'd0));
    reset = 1'b1;
    cyc(4'h4, 4'h8, 4'h0, 1'b0, 1'b0, mk(3'd0));
    fetch_decode(4'h4, 4'h8, 4'h0, 1'b0);
    reset = 1'b0;
    cyc(4'h4, 4'h8, 4'h0, 1'b0, 1'b1, mk(3'd0));
    reset = 1'b1;
    fetch_decode(4'h4, 4'h0, 4'h0, 1'b0);
    reset = 1'b0;
    cyc(4'h4, 4'h0, 4'h0, 1'b0, 1'b1, mk(3'd0));
    reset = 1'b1;
    cyc(4'h4, 4'h0, 4'h0, 1'b0, 1'b0, mk(3'd0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_mid: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    fetch_decode(4'h0, 4'h3, 4'h0, 1'b0);
    e    = mk(3'd2);
    e.as = 1'b1;
    e.rw = 1'b1;
    e.ac = 6'h03;
    cyc(4'h0, 4'h3, 4'h0, 1'b0, 1'b1, e);
    fetch_decode(4'h4, 4'h0, 4'h0, 1'b0);
    e     = mk(3'd4);
    e.ld  = 1'b1;
    e.rw  = 1'b1;
    e.rws = 2'd1;
    cyc(4'h4, 4'h0, 4'h0, 1'b0, 1'b1, e);
    fetch_decode(4'h4, 4'h4, 4'h0, 1'b0);
    e     = mk(3'd5);
    e.sto = 1'b1;
    cyc(4'h4, 4'h4, 4'h0, 1'b0, 1'b1, e);
    fetch_decode(4'h9, 4'h0, 4'h0, 1'b0);
    e    = mk(3'd3);
    e.as = 1'b1;
    e.bs = 1'b1;
    e.rw = 1'b1;
    e.ac = 6'h09;
    cyc(4'h9, 4'h0, 4'h0, 1'b0, 1'b1, e);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL back_to_back: got %h want %h", o, e);
      end
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b0;
    op_code     = 4'h0;
    ext_op_code = 4'h0;
    cond        = 4'h0;
    psr_flags   = 16'h0000;
    mem_ready   = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_jal();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
